rf_write_arbiter: RTL
=====================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 3, number of write-back requesters (2..8); index 0 = ALU, 1 = load unit, 2 = CSR unit.
REQ-002 Parameter: DATA_WIDTH, 32, register value width.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: hold  input  1  when high, no request is granted this cycle.
REQ-006 Port: req_valid  input  NUM_REQ  per-requester write request.
REQ-007 Port: req_address  input  NUM_REQ*5  per-requester destination register, requester i in bits [5i+4:5i].
REQ-008 Port: req_value  input  NUM_REQ*DATA_WIDTH  per-requester write data, requester i in slice i.
REQ-009 Port: req_ready  output  NUM_REQ  one-hot-or-zero grant; transfer occurs when req_valid[i] and req_ready[i] are high in the same cycle.
REQ-010 Port: write_enable  output  1  registered write strobe to the register file write port.
REQ-011 Port: address_write  output  5  registered destination address.
REQ-012 Port: value_write  output  DATA_WIDTH  registered write data.
REQ-013 Port: write_source  output  3  registered index of the requester that produced the current write.
REQ-014 Port: pending_valid  output  1  equals write_enable; lets decode bypass the in-flight write.
REQ-015 Port: pending_address  output  5  equals address_write when pending_valid is high, else 0.

Function
REQ-016 req_ready SHALL be combinational from req_valid, hold and the priority pointer; at most one bit high per cycle.
REQ-017 With hold low, req_ready SHALL grant the first requester with req_valid high, searching from the pointer index upward and wrapping modulo NUM_REQ.
REQ-018 With hold high, or with no req_valid bit high, req_ready SHALL be all zero.
REQ-019 After a grant to requester g, the pointer SHALL become (g+1) mod NUM_REQ at the next edge; with no grant the pointer SHALL be unchanged.
REQ-020 An accepted request SHALL appear on write_enable/address_write/value_write/write_source exactly one cycle after acceptance (latency 1), for one cycle only.
REQ-021 An accepted request with address 0 SHALL be consumed (ready high, pointer advances) but SHALL NOT assert write_enable; address_write, value_write and write_source SHALL still update.
REQ-022 In a cycle with no acceptance, write_enable SHALL be 0 at the next edge; address_write, value_write and write_source SHALL hold their previous values.
REQ-023 Sustained throughput SHALL be one write per cycle with no bubbles while any requester is valid and hold is low.
REQ-024 Requesters SHALL keep req_valid, req_address and req_value stable until accepted; the block SHALL NOT register unaccepted requests.
REQ-025 A requester valid for NUM_REQ consecutive cycles with hold low SHALL be granted within those cycles (starvation bound).
REQ-026 Assertion of hold SHALL NOT cancel a write already registered; it appears on the next cycle as normal.

Reset
REQ-027 While reset_n is low: pointer = 0, write_enable = 0, address_write = 0, value_write = 0, write_source = 0, pending_valid = 0, pending_address = 0.
REQ-028 While reset_n is low, req_ready SHALL be all zero.
REQ-029 Reset asserted mid-operation SHALL discard the registered write; write_enable SHALL fall asynchronously, with no write issued after reset release.
REQ-030 The first grant after reset release SHALL follow REQ-017 starting from pointer 0.

Verification
REQ-031 Single request: req_valid=001, address 5, value 0xDEADBEEF -> req_ready=001 same cycle; next cycle write_enable=1, address_write=5, value_write=0xDEADBEEF, write_source=0.
REQ-032 Round robin: req_valid=111 held 6 cycles from reset -> grants 0,1,2,0,1,2; write_enable high for 6 consecutive cycles, each one cycle after its grant.
REQ-033 Zero register: requester 1 valid, address 0, value 0x12345678 -> req_ready=010; next cycle write_enable=0, pending_valid=0; pointer advances to 2.
REQ-034 Hold: req_valid=110 with hold high for 3 cycles -> req_ready=000, write_enable=0 throughout; hold low -> grant to 1 (pointer 0, first valid at or above 0).
REQ-035 Reset mid-write: accept requester 2 (address 9), pull reset_n low before the next edge -> write_enable stays 0, all outputs 0; after release, req_valid=100 -> grant to 2 from pointer 0.
REQ-036 Starvation: requester 0 valid continuously, requester 2 raised in cycle 3 -> requester 2 granted within 3 cycles.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Write-back bus between the requesters (ALU, load unit, CSR unit) and the
// register-file write arbiter, plus the registered write port and bypass view.
interface rf_write_arbiter_if #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                           hold;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*5-1:0]           req_address;
  logic [NUM_REQ*DATA_WIDTH-1:0]  req_value;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           write_enable;
  logic [4:0]                     address_write;
  logic [DATA_WIDTH-1:0]          value_write;
  logic [2:0]                     write_source;
  logic                           pending_valid;
  logic [4:0]                     pending_address;

  // Requester / pipeline side.
  modport master (
    output hold, req_valid, req_address, req_value,
    input  req_ready, write_enable, address_write, value_write, write_source,
           pending_valid, pending_address
  );

  // Arbiter side.
  modport slave (
    input  hold, req_valid, req_address, req_value,
    output req_ready, write_enable, address_write, value_write, write_source,
           pending_valid, pending_address
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single register-file write port. One request is
// granted per cycle (combinational ready), and the winner is registered onto the
// write port with a latency of one cycle. Writes to x0 are consumed but dropped.
module rf_write_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               reset_n,
  rf_write_arbiter_if.slave bus
);
  localparam int unsigned     IdxW    = $clog2(NUM_REQ);
  localparam logic [IdxW:0]   NumReqW = (IdxW + 1)'(NUM_REQ);

  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    grant;
  logic [IdxW-1:0]       gnt_idx;
  logic                  accept;
  logic [4:0]            sel_addr;
  logic [DATA_WIDTH-1:0] sel_val;

  logic                  we_q;
  logic [4:0]            addr_q;
  logic [DATA_WIDTH-1:0] val_q;
  logic [2:0]            src_q;

  // Search upward from the pointer, wrapping, for the first valid requester.
  always_comb begin
    logic [IdxW:0] cand;
    cand    = '0;
    grant   = '0;
    gnt_idx = '0;
    accept  = 1'b0;
    if (reset_n && !bus.hold) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        cand = {1'b0, ptr_q} + (IdxW + 1)'(k);
        if (cand >= NumReqW) cand = cand - NumReqW;
        if (!accept && bus.req_valid[cand[IdxW-1:0]]) begin
          accept  = 1'b1;
          gnt_idx = cand[IdxW-1:0];
        end
      end
    end
    if (accept) grant[gnt_idx] = 1'b1;
  end

  // Mux the winner's address/data and compute the next priority pointer.
  always_comb begin
    sel_addr = '0;
    sel_val  = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (gnt_idx == IdxW'(k)) begin
        sel_addr = bus.req_address[5*k +: 5];
        sel_val  = bus.req_value[DATA_WIDTH*k +: DATA_WIDTH];
      end
    end
    ptr_d = ptr_q;
    if (accept) ptr_d = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Register the accepted write; reset discards any write in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      val_q  <= '0;
      src_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      we_q  <= accept && (sel_addr != 5'd0);
      if (accept) begin
        addr_q <= sel_addr;
        val_q  <= sel_val;
        src_q  <= 3'(gnt_idx);
      end
    end
  end

  // Drive the bus; the bypass view masks the address when nothing is in flight.
  always_comb begin
    bus.req_ready       = grant;
    bus.write_enable    = we_q;
    bus.address_write   = addr_q;
    bus.value_write     = val_q;
    bus.write_source    = src_q;
    bus.pending_valid   = we_q;
    bus.pending_address = we_q ? addr_q : 5'd0;
  end
endmodule
